// File: rtl/bus_pkg.sv
// Shared widths, direction constants, state and command types for the bus master sequencer.
package bus_pkg;

   localparam int unsigned BUS_ADDR_W = 16;
   localparam int unsigned BUS_DATA_W = 16;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StReq     = 3'd1,
      StXfer    = 3'd2,
      StRelease = 3'd3,
      StResp    = 3'd4
   } bus_master_state_t;

   typedef struct packed {
      logic                  rw;
      logic [BUS_ADDR_W-1:0] addr;
      logic [BUS_DATA_W-1:0] wdata;
   } bus_cmd_t;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Saturating cycle counter with synchronous clear; hit_o flags count at or beyond limit_i.
module bus_timeout_cnt #(
   parameter int unsigned Width = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [Width-1:0] limit_i,
   output logic             hit_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + Width'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_o = (cnt_q >= limit_i);

endmodule

// File: rtl/bus_master_ctrl.sv
// Master-side sequencer: takes one command, requests the bus, runs the transfer with
// grant/transfer timeouts and retries, releases the bus and returns a one-cycle response.
module bus_master_ctrl
   import bus_pkg::*;
#(
   parameter int unsigned ADDR_W        = BUS_ADDR_W,
   parameter int unsigned DATA_W        = BUS_DATA_W,
   parameter int unsigned GRANT_TIMEOUT = 32,
   parameter int unsigned XFER_TIMEOUT  = 16,
   parameter int unsigned MAX_RETRIES   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_rw_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_error_o,
   output logic              barq_o,
   input  logic              bagd_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              rw_o,
   output logic [DATA_W-1:0] wdata_o,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic              data_strobe_i,
   input  logic              arb_error_i
);

   localparam int unsigned CntMax = (GRANT_TIMEOUT > XFER_TIMEOUT) ? GRANT_TIMEOUT : XFER_TIMEOUT;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned RetW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [CntW-1:0] GrantLimit = CntW'(GRANT_TIMEOUT - 1);
   localparam logic [CntW-1:0] XferLimit  = CntW'(XFER_TIMEOUT - 1);

   bus_master_state_t state_q, state_d;
   bus_cmd_t          cmd_q, cmd_d;
   logic              err_q, err_d;
   logic              retry_q, retry_d;
   logic [RetW-1:0]   retries_q, retries_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic            cnt_clr, cnt_en, cnt_hit;
   logic [CntW-1:0] cnt_limit;
   logic            bus_drive;

   // One counter serves both phases; it is cleared on every phase change.
   bus_timeout_cnt #(
      .Width (CntW)
   ) u_timeout_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .limit_i (cnt_limit),
      .hit_o   (cnt_hit)
   );

   assign cnt_limit = (state_q == StReq) ? GrantLimit : XferLimit;

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      err_d     = err_q;
      retry_d   = retry_q;
      retries_d = retries_q;
      rdata_d   = rdata_q;
      cnt_clr   = 1'b1;
      cnt_en    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               cmd_d     = '{rw: cmd_rw_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
               err_d     = 1'b0;
               retry_d   = 1'b0;
               retries_d = '0;
               rdata_d   = '0;
               state_d   = StReq;
            end
         end
         StReq: begin
            cnt_clr = 1'b0;
            cnt_en  = 1'b1;
            if (arb_error_i || (!bagd_i && cnt_hit)) begin
               err_d   = 1'b1;
               state_d = StRelease;
            end else if (bagd_i) begin
               cnt_clr = 1'b1;
               state_d = StXfer;
            end
         end
         StXfer: begin
            cnt_clr = 1'b0;
            cnt_en  = 1'b1;
            if (arb_error_i) begin
               err_d   = 1'b1;
               state_d = StRelease;
            end else if (data_strobe_i) begin
               rdata_d = (cmd_q.rw == RW_READ) ? rdata_i : '0;
               state_d = StRelease;
            end else if (!bagd_i || cnt_hit) begin
               // A lost grant is handled exactly like a transfer timeout.
               if (32'(retries_q) < MAX_RETRIES) begin
                  retries_d = retries_q + RetW'(1);
                  retry_d   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = StRelease;
            end
         end
         StRelease: begin
            if (!bagd_i) begin
               retry_d = 1'b0;
               state_d = retry_q ? StReq : StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cmd_q     <= '0;
         err_q     <= 1'b0;
         retry_q   <= 1'b0;
         retries_q <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         err_q     <= err_d;
         retry_q   <= retry_d;
         retries_q <= retries_d;
         rdata_q   <= rdata_d;
      end
   end

   // Gating with rst drops the request in the very cycle reset is sampled.
   assign bus_drive   = (state_q == StXfer) && bagd_i && !rst;
   assign barq_o      = ((state_q == StReq) || (state_q == StXfer)) && !rst;
   assign cmd_ready_o = (state_q == StIdle) && !rst;

   assign addr_o  = bus_drive ? cmd_q.addr : '0;
   assign rw_o    = bus_drive && (cmd_q.rw == RW_WRITE);
   assign wdata_o = (bus_drive && (cmd_q.rw == RW_WRITE)) ? cmd_q.wdata : '0;

   assign rsp_valid_o = (state_q == StResp);
   assign rsp_error_o = rsp_valid_o && err_q;
   assign rsp_rdata_o = (rsp_valid_o && !err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Self-checking bench: reactive arbiter/slave model around the DUT, directed scenarios and a
// randomized phase with outcomes predicted arithmetically from the chosen arbiter delays.
module tb_bus_master_ctrl;

   localparam int GT = 32;
   localparam int XT = 16;
   localparam int MR = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid_i, cmd_ready_o, cmd_rw_i;
   logic [15:0] cmd_addr_i, cmd_wdata_i;
   logic        rsp_valid_o, rsp_error_o;
   logic [15:0] rsp_rdata_o;
   logic        barq_o, bagd_i, rw_o, data_strobe_i, arb_error_i;
   logic [15:0] addr_o, wdata_o, rdata_i;

   int n_checks = 0;
   int n_fail   = 0;

   // Per-attempt arbiter behaviour: grant delay, strobe index, grant-drop index, arb-error index.
   int g_cfg[3];
   int s_cfg[3];
   int d_cfg[3];
   int a_cfg[3];
   int rd_cfg;

   int          obs_rsp_cnt, obs_err, obs_hi, obs_att, obs_drive_ok, obs_drive_any;
   int          obs_rsp_cycle, obs_ready_after, obs_accept;
   logic [15:0] obs_rdata;

   int          exp_err, exp_hi, exp_att, exp_drive, exp_cycle;
   logic [15:0] exp_rdata;

   always #5 clk = ~clk;

   bus_master_ctrl #(
      .ADDR_W        (16),
      .DATA_W        (16),
      .GRANT_TIMEOUT (GT),
      .XFER_TIMEOUT  (XT),
      .MAX_RETRIES   (MR)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_rw_i      (cmd_rw_i),
      .cmd_addr_i    (cmd_addr_i),
      .cmd_wdata_i   (cmd_wdata_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_rdata_o   (rsp_rdata_o),
      .rsp_error_o   (rsp_error_o),
      .barq_o        (barq_o),
      .bagd_i        (bagd_i),
      .addr_o        (addr_o),
      .rw_o          (rw_o),
      .wdata_o       (wdata_o),
      .rdata_i       (rdata_i),
      .data_strobe_i (data_strobe_i),
      .arb_error_i   (arb_error_i)
   );

   task automatic set_cfg(input int g, input int s, input int d, input int a);
      for (int i = 0; i < 3; i++) begin
         g_cfg[i] = g;
         s_cfg[i] = s;
         d_cfg[i] = d;
         a_cfg[i] = a;
      end
   endtask

   // Issues one command and plays arbiter/slave: grant g cycles into each barq run, strobe s
   // cycles into the transfer, hold grant rd cycles after barq falls. Records observations.
   task automatic run_txn(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rdata);
      int   hi, rel, att, ai, rsp_at;
      logic b, prev_b, bagd_was;
      obs_rsp_cnt = 0; obs_err = 0; obs_rdata = '0; obs_hi = 0; obs_att = 0;
      obs_drive_ok = 0; obs_drive_any = 0; obs_ready_after = 0; obs_accept = 0;
      hi = 0; rel = 0; att = -1; ai = 0; rsp_at = -1; prev_b = 1'b0; bagd_was = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         b             = barq_o;
         cmd_valid_i   = (cyc == 0);
         cmd_rw_i      = (cyc == 0) ? rw : 1'($urandom);
         cmd_addr_i    = (cyc == 0) ? addr : 16'($urandom);
         cmd_wdata_i   = (cyc == 0) ? wdata : 16'($urandom);
         data_strobe_i = 1'b0;
         arb_error_i   = 1'b0;
         rdata_i       = 16'($urandom);
         if (b) begin
            if (!prev_b) begin
               hi = 0;
               att++;
               obs_att++;
            end else begin
               hi++;
            end
            ai = (att > 2) ? 2 : att;
            bagd_i = (hi >= g_cfg[ai]) &&
                     !(d_cfg[ai] >= 0 && hi >= g_cfg[ai] + 1 + d_cfg[ai]);
            if (hi == g_cfg[ai] + 1 + s_cfg[ai]) begin
               data_strobe_i = 1'b1;
               rdata_i       = rdata;
            end
            if (a_cfg[ai] >= 0 && hi == g_cfg[ai] + 1 + a_cfg[ai]) arb_error_i = 1'b1;
            bagd_was = bagd_i;
         end else begin
            rel    = prev_b ? 0 : rel + 1;
            bagd_i = bagd_was && (rel < rd_cfg);
         end
         prev_b = b;
         #1;
         if (cyc == 0) obs_accept = int'(cmd_ready_o);
         if (b) obs_hi++;
         if (addr_o != '0 || rw_o || wdata_o != '0) obs_drive_any++;
         if (addr_o == addr && rw_o == rw && wdata_o == (rw ? wdata : 16'h0)) obs_drive_ok++;
         if (rsp_valid_o) begin
            obs_rsp_cnt++;
            if (rsp_at < 0) begin
               rsp_at    = cyc;
               obs_err   = int'(rsp_error_o);
               obs_rdata = rsp_rdata_o;
            end
         end
         if (rsp_at >= 0 && cyc == rsp_at + 1) obs_ready_after = int'(cmd_ready_o);
         if (rsp_at >= 0 && cyc == rsp_at + 3) break;
      end
      obs_rsp_cycle = rsp_at;
      cmd_valid_i = 1'b0; bagd_i = 1'b0; data_strobe_i = 1'b0; arb_error_i = 1'b0;
   endtask

   // Outcome from the arbiter delays alone: each attempt ends at the first of arb error,
   // strobe, lost grant or the transfer window; retries until MR exhausted.
   task automatic model(input logic rw, input logic [15:0] rdata);
      int h, k, kind;
      bit fin;
      exp_err = 0; exp_rdata = '0; exp_hi = 0; exp_att = 0; exp_drive = 0; exp_cycle = 1;
      fin = 1'b0;
      for (int i = 0; i <= MR && !fin; i++) begin
         exp_att++;
         if (g_cfg[i] >= GT) begin
            h = GT;
            exp_err = 1;
            fin = 1'b1;
            exp_cycle += h + 1;
         end else begin
            k = 0;
            kind = 0;
            while (kind == 0) begin
               if (a_cfg[i] == k) kind = 2;
               else if (s_cfg[i] == k) kind = 1;
               else if (d_cfg[i] == k) kind = 4;
               else if (k == XT - 1) kind = 3;
               else k++;
            end
            h = g_cfg[i] + k + 2;
            exp_drive += (kind == 4) ? k : k + 1;
            exp_cycle += h + ((kind == 4) ? 1 : rd_cfg + 1);
            if (kind == 1) begin
               fin = 1'b1;
               exp_rdata = rw ? 16'h0 : rdata;
            end else if (kind == 2 || i == MR) begin
               fin = 1'b1;
               exp_err = 1;
            end
         end
         exp_hi += h;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid_i = 1'b1; bagd_i = 1'b1; data_strobe_i = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if ({barq_o, cmd_ready_o, rsp_valid_o, rsp_error_o, rw_o} !== 5'b0 ||
          addr_o !== 16'h0 || wdata_o !== 16'h0 || rsp_rdata_o !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: barq=%b ready=%b rsp=%b err=%b addr=%h, required all 0",
                  barq_o, cmd_ready_o, rsp_valid_o, rsp_error_o, addr_o);
      end
      @(negedge clk);
      rst = 1'b0; cmd_valid_i = 1'b0; bagd_i = 1'b0; data_strobe_i = 1'b0;
      #1;
      n_checks++;
      if (cmd_ready_o !== 1'b1 || barq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: ready=%b barq=%b, required 1/0", cmd_ready_o, barq_o);
      end
   endtask

   task automatic test_read();
      set_cfg(2, 1, -1, -1); rd_cfg = 1;
      run_txn(1'b0, 16'd50, 16'hFFFF, 16'h01BC);
      n_checks++;
      if (obs_err !== 0 || obs_rdata !== 16'h01BC || obs_rsp_cnt !== 1) begin
         n_fail++;
         $display("FAIL read_rsp: err=%0d rdata=%h pulses=%0d, required 0/01bc/1",
                  obs_err, obs_rdata, obs_rsp_cnt);
      end
      n_checks++;
      if (obs_drive_ok !== 2 || obs_drive_any !== 2 || obs_hi !== 5) begin
         n_fail++;
         $display("FAIL read_bus: addr50 cycles=%0d driven=%0d barq cycles=%0d, required 2/2/5",
                  obs_drive_ok, obs_drive_any, obs_hi);
      end
      n_checks++;
      if (obs_rsp_cycle !== 8 || obs_accept !== 1) begin
         n_fail++;
         $display("FAIL read_latency: rsp at %0d accept=%0d, required 8/1",
                  obs_rsp_cycle, obs_accept);
      end
   endtask

   task automatic test_write();
      set_cfg(0, 2, -1, -1); rd_cfg = 0;
      run_txn(1'b1, 16'd44, 16'd444, 16'hABCD);
      n_checks++;
      if (obs_err !== 0 || obs_rdata !== 16'h0 || obs_rsp_cycle !== 6) begin
         n_fail++;
         $display("FAIL write_rsp: err=%0d rdata=%h rsp at %0d, required 0/0000/6",
                  obs_err, obs_rdata, obs_rsp_cycle);
      end
      n_checks++;
      if (obs_drive_ok !== 3 || obs_drive_any !== 3) begin
         n_fail++;
         $display("FAIL write_bus: wdata444 cycles=%0d driven=%0d, required 3/3",
                  obs_drive_ok, obs_drive_any);
      end
   endtask

   task automatic test_grant_timeout();
      set_cfg(99, 0, -1, -1); rd_cfg = 2;
      run_txn(1'b0, 16'h0F0F, 16'h0, 16'h1111);
      n_checks++;
      if (obs_hi !== GT || obs_att !== 1 || obs_drive_any !== 0) begin
         n_fail++;
         $display("FAIL grant_timeout_barq: cycles=%0d runs=%0d driven=%0d, required 32/1/0",
                  obs_hi, obs_att, obs_drive_any);
      end
      n_checks++;
      if (obs_err !== 1 || obs_rsp_cycle !== 34) begin
         n_fail++;
         $display("FAIL grant_timeout_rsp: err=%0d rsp at %0d, required 1/34",
                  obs_err, obs_rsp_cycle);
      end
   endtask

   task automatic test_retries();
      set_cfg(0, 99, -1, -1); rd_cfg = 1;
      run_txn(1'b0, 16'h2222, 16'h0, 16'h3333);
      n_checks++;
      if (obs_att !== 3 || obs_hi !== 51 || obs_drive_ok !== 48) begin
         n_fail++;
         $display("FAIL retries_phases: runs=%0d barq=%0d driven=%0d, required 3/51/48",
                  obs_att, obs_hi, obs_drive_ok);
      end
      n_checks++;
      if (obs_err !== 1 || obs_rsp_cycle !== 58 || obs_ready_after !== 1) begin
         n_fail++;
         $display("FAIL retries_rsp: err=%0d rsp at %0d ready=%0d, required 1/58/1",
                  obs_err, obs_rsp_cycle, obs_ready_after);
      end
   endtask

   task automatic test_arb_error();
      set_cfg(1, 3, -1, 3); rd_cfg = 0;
      run_txn(1'b0, 16'h4444, 16'h0, 16'hBEEF);
      n_checks++;
      if (obs_err !== 1 || obs_rdata !== 16'h0 || obs_hi !== 6 || obs_att !== 1) begin
         n_fail++;
         $display("FAIL arb_error: err=%0d rdata=%h barq=%0d runs=%0d, required 1/0000/6/1",
                  obs_err, obs_rdata, obs_hi, obs_att);
      end
   endtask

   task automatic test_timeout_boundary();
      set_cfg(0, XT - 1, -1, -1); rd_cfg = 0;
      run_txn(1'b0, 16'h5555, 16'h0, 16'h5A5A);
      n_checks++;
      if (obs_err !== 0 || obs_rdata !== 16'h5A5A || obs_att !== 1 || obs_hi !== 17) begin
         n_fail++;
         $display("FAIL strobe_at_limit: err=%0d rdata=%h runs=%0d barq=%0d, req 0/5a5a/1/17",
                  obs_err, obs_rdata, obs_att, obs_hi);
      end
   endtask

   task automatic test_grant_drop();
      set_cfg(0, 0, -1, -1); rd_cfg = 1;
      s_cfg[0] = 99; d_cfg[0] = 2;
      run_txn(1'b0, 16'h6666, 16'h0, 16'h1357);
      n_checks++;
      if (obs_att !== 2 || obs_err !== 0 || obs_rdata !== 16'h1357) begin
         n_fail++;
         $display("FAIL grant_drop_retry: runs=%0d err=%0d rdata=%h, required 2/0/1357",
                  obs_att, obs_err, obs_rdata);
      end
      n_checks++;
      if (obs_hi !== 6 || obs_drive_ok !== 3 || obs_rsp_cycle !== 10) begin
         n_fail++;
         $display("FAIL grant_drop_timing: barq=%0d driven=%0d rsp at %0d, required 6/3/10",
                  obs_hi, obs_drive_ok, obs_rsp_cycle);
      end
   endtask

   task automatic test_reset_mid_xfer();
      int seen;
      seen = 0;
      @(negedge clk);
      cmd_valid_i = 1'b1; cmd_rw_i = 1'b0; cmd_addr_i = 16'h1234; bagd_i = 1'b1;
      @(negedge clk);
      cmd_valid_i = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if (addr_o !== 16'h1234) begin
         n_fail++;
         $display("FAIL midrst_xfer_addr: addr=%h, required 1234", addr_o);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (barq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_same_cycle: barq=%b, required 0", barq_o);
      end
      @(negedge clk);
      rst = 1'b0; bagd_i = 1'b0;
      #1;
      n_checks++;
      if (barq_o !== 1'b0 || addr_o !== 16'h0 || cmd_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_after: barq=%b addr=%h ready=%b, required 0/0000/1",
                  barq_o, addr_o, cmd_ready_o);
      end
      repeat (6) begin
         @(negedge clk);
         #1;
         if (rsp_valid_o) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL midrst_no_rsp: pulses=%0d, required 0", seen);
      end
      set_cfg(1, 0, -1, -1); rd_cfg = 0;
      run_txn(1'b0, 16'h7777, 16'h0, 16'hC0DE);
      n_checks++;
      if (obs_err !== 0 || obs_rdata !== 16'hC0DE || obs_rsp_cnt !== 1) begin
         n_fail++;
         $display("FAIL midrst_recover: err=%0d rdata=%h pulses=%0d, required 0/c0de/1",
                  obs_err, obs_rdata, obs_rsp_cnt);
      end
   endtask

   task automatic test_random();
      logic        rw;
      logic [15:0] addr, wdata, rdata;
      for (int it = 0; it < 30; it++) begin
         for (int i = 0; i < 3; i++) begin
            g_cfg[i] = ($urandom_range(0, 9) == 0) ? 33 : int'($urandom_range(0, 4));
            s_cfg[i] = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, XT - 1)) : 20;
            d_cfg[i] = -1;
            if ($urandom_range(0, 6) == 0 && s_cfg[i] > 0)
               d_cfg[i] = int'($urandom_range(0, s_cfg[i] - 1));
            a_cfg[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
         end
         rd_cfg = int'($urandom_range(0, 3));
         rw     = 1'($urandom);
         addr   = 16'($urandom_range(1, 16'hFFFF));
         wdata  = 16'($urandom);
         rdata  = 16'($urandom);
         model(rw, rdata);
         run_txn(rw, addr, wdata, rdata);
         n_checks++;
         if (obs_err !== exp_err || obs_rdata !== exp_rdata || obs_rsp_cnt !== 1) begin
            n_fail++;
            $display("FAIL rand%0d_rsp: err=%0d rdata=%h pulses=%0d, required %0d/%h/1",
                     it, obs_err, obs_rdata, obs_rsp_cnt, exp_err, exp_rdata);
         end
         n_checks++;
         if (obs_hi !== exp_hi || obs_att !== exp_att || obs_rsp_cycle !== exp_cycle) begin
            n_fail++;
            $display("FAIL rand%0d_timing: barq=%0d runs=%0d rsp at %0d, required %0d/%0d/%0d",
                     it, obs_hi, obs_att, obs_rsp_cycle, exp_hi, exp_att, exp_cycle);
         end
         n_checks++;
         if (obs_drive_ok !== exp_drive || obs_drive_any !== exp_drive) begin
            n_fail++;
            $display("FAIL rand%0d_bus: correct=%0d driven=%0d, required %0d",
                     it, obs_drive_ok, obs_drive_any, exp_drive);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cmd_valid_i = 1'b0; cmd_rw_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
      bagd_i = 1'b0; rdata_i = '0; data_strobe_i = 1'b0; arb_error_i = 1'b0;
      test_reset();
      test_read();
      test_write();
      test_grant_timeout();
      test_retries();
      test_arb_error();
      test_timeout_boundary();
      test_grant_drop();
      test_reset_mid_xfer();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
